can_rx_framer: RTL

- Listen-only CAN receive framer: takes one sampled bus bit per bit time, removes stuff bits, and tracks frame fields from SOF to EOF.
- Drives the downstream CRC-15 shift stage (en/din/rst) and consumes its zero flag at the CRC delimiter.
- Emits the decoded ID, DLC and data, a frame-valid pulse and error pulses. Sits between the bit-timing/sampling stage and host-side frame buffering.

---
 rtl/can_rx_framer.sv | 353 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/can_rx_framer.sv
// Listen-only CAN receive framer: destuffs sampled bus bits, walks the frame fields
// from SOF to EOF, feeds the external CRC-15 stage and reports frames and errors.
// Optional extended-identifier reception is enabled by defining CAN_EXT_ID_EN.
module can_rx_framer #(
  parameter int EOF_BITS  = 7,
  parameter int IDLE_BITS = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample,
  input  logic        rxbit,
  input  logic        crc_zero,
  output logic        crc_en,
  output logic        crc_din,
  output logic        crc_clr,
  output logic [28:0] frame_id,
  output logic        frame_ide,
  output logic        frame_rtr,
  output logic [3:0]  frame_dlc,
  output logic [63:0] frame_data,
  output logic        frame_valid,
  output logic        stuff_err,
  output logic        crc_err,
  output logic        form_err,
  output logic        busy
);

  localparam int RW = $clog2(IDLE_BITS + 1);

  typedef enum logic [3:0] {
    S_WAIT_IDLE, S_IDLE, S_ARB, S_EXT, S_CTRL, S_DATA,
    S_CRC, S_CRCDEL, S_ACK, S_ACKDEL, S_EOF
  } state_t;

  state_t        state_r, state_s;
  logic [6:0]    cnt_r, cnt_s;
  logic [RW-1:0] rec_r, rec_s;
  logic [2:0]    run_r, run_s;
  logic          last_r, last_s;
  logic [28:0]   id_r, id_s;
  logic          rtr_r, rtr_s;
  logic [3:0]    dlc_r, dlc_s;
  logic [63:0]   data_r, data_s;
  logic [6:0]    nbits_r, nbits_s;
  logic          sof_pend_r;
  logic [3:0]    bytes_s;
  logic          stuff_act_s, take_s;
  logic          en_s, din_s, clr_s, valid_s, stuff_s, crcerr_s, form_s;
`ifdef CAN_EXT_ID_EN
  logic          ide_r, ide_s;
`endif

  // Frame-tracking state, advanced only on sample strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_WAIT_IDLE;
      cnt_r      <= 7'd0;
      rec_r      <= {RW{1'b0}};
      run_r      <= 3'd0;
      last_r     <= 1'b0;
      id_r       <= 29'd0;
      rtr_r      <= 1'b0;
      dlc_r      <= 4'd0;
      data_r     <= 64'd0;
      nbits_r    <= 7'd0;
      sof_pend_r <= 1'b0;
`ifdef CAN_EXT_ID_EN
      ide_r      <= 1'b0;
`endif
    end else begin
      sof_pend_r <= sample & clr_s;
      if (sample) begin
        state_r <= state_s;
        cnt_r   <= cnt_s;
        rec_r   <= rec_s;
        run_r   <= run_s;
        last_r  <= last_s;
        id_r    <= id_s;
        rtr_r   <= rtr_s;
        dlc_r   <= dlc_s;
        data_r  <= data_s;
        nbits_r <= nbits_s;
`ifdef CAN_EXT_ID_EN
        ide_r   <= ide_s;
`endif
      end
    end
  end

  // Destuffing, field sequencing and error detection for the current sample
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    rec_s    = rec_r;
    run_s    = run_r;
    last_s   = last_r;
    id_s     = id_r;
    rtr_s    = rtr_r;
    dlc_s    = dlc_r;
    data_s   = data_r;
    nbits_s  = nbits_r;
`ifdef CAN_EXT_ID_EN
    ide_s    = ide_r;
`endif
    bytes_s  = 4'd0;
    en_s     = 1'b0;
    din_s    = 1'b0;
    clr_s    = 1'b0;
    valid_s  = 1'b0;
    stuff_s  = 1'b0;
    crcerr_s = 1'b0;
    form_s   = 1'b0;

    stuff_act_s = (state_r == S_ARB) || (state_r == S_EXT) || (state_r == S_CTRL) ||
                  (state_r == S_DATA) || (state_r == S_CRC);
    take_s      = stuff_act_s && (run_r != 3'd5);

    // The run length includes stuff bits; a stuff bit restarts the run at 1
    if (stuff_act_s) begin
      last_s = rxbit;
      if (run_r == 3'd5) begin
        run_s = 3'd1;
        if (rxbit == last_r) begin
          stuff_s = 1'b1;
          state_s = S_WAIT_IDLE;
          rec_s   = {RW{1'b0}};
        end else begin
          stuff_s = 1'b0;
        end
      end else if (rxbit == last_r) begin
        run_s = run_r + 3'd1;
      end else begin
        run_s = 3'd1;
      end
    end else begin
      run_s = run_r;
    end

    if (take_s) begin
      en_s  = 1'b1;
      din_s = rxbit;
    end else begin
      en_s  = 1'b0;
    end

    case (state_r)
      S_WAIT_IDLE: begin
        if (rxbit) begin
          if (rec_r == RW'(IDLE_BITS - 1)) begin
            state_s = S_IDLE;
            rec_s   = {RW{1'b0}};
          end else begin
            rec_s = rec_r + RW'(1);
          end
        end else begin
          rec_s = {RW{1'b0}};
        end
      end
      S_IDLE: begin
        if (!rxbit) begin
          clr_s   = 1'b1;
          state_s = S_ARB;
          cnt_s   = 7'd0;
          run_s   = 3'd1;
          last_s  = 1'b0;
          id_s    = 29'd0;
          rtr_s   = 1'b0;
          dlc_s   = 4'd0;
          data_s  = 64'd0;
`ifdef CAN_EXT_ID_EN
          ide_s   = 1'b0;
`endif
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ARB: begin
        if (take_s) begin
          if (cnt_r < 7'd11) begin
            id_s  = {id_r[27:0], rxbit};
            cnt_s = cnt_r + 7'd1;
          end else if (cnt_r == 7'd11) begin
            rtr_s = rxbit;
            cnt_s = cnt_r + 7'd1;
          end else begin
            cnt_s = 7'd0;
            if (!rxbit) begin
              state_s = S_CTRL;
            end else begin
`ifdef CAN_EXT_ID_EN
              ide_s   = 1'b1;
              state_s = S_EXT;
`else
              state_s = S_WAIT_IDLE;
              rec_s   = {RW{1'b0}};
`endif
            end
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
`ifdef CAN_EXT_ID_EN
      S_EXT: begin
        // 18 identifier bits, RTR, r1; r0 and DLC are then taken by CTRL
        if (take_s) begin
          if (cnt_r < 7'd18) begin
            id_s  = {id_r[27:0], rxbit};
            cnt_s = cnt_r + 7'd1;
          end else if (cnt_r == 7'd18) begin
            rtr_s = rxbit;
            cnt_s = cnt_r + 7'd1;
          end else begin
            cnt_s   = 7'd0;
            state_s = S_CTRL;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
`endif
      S_CTRL: begin
        if (take_s) begin
          if (cnt_r == 7'd0) begin
            cnt_s = 7'd1;
          end else begin
            dlc_s = {dlc_r[2:0], rxbit};
            if (cnt_r == 7'd4) begin
              bytes_s = rtr_r ? 4'd0 : (dlc_s[3] ? 4'd8 : dlc_s);
              nbits_s = {bytes_s, 3'b000};
              cnt_s   = 7'd0;
              state_s = (bytes_s == 4'd0) ? S_CRC : S_DATA;
            end else begin
              cnt_s = cnt_r + 7'd1;
            end
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      S_DATA: begin
        // Bit n lands at [63-n] so the first byte ends up in [63:56]
        if (take_s) begin
          data_s[~cnt_r[5:0]] = rxbit;
          if (cnt_r == nbits_r - 7'd1) begin
            cnt_s   = 7'd0;
            state_s = S_CRC;
          end else begin
            cnt_s = cnt_r + 7'd1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      S_CRC: begin
        if (take_s) begin
          if (cnt_r == 7'd14) begin
            cnt_s   = 7'd0;
            state_s = S_CRCDEL;
          end else begin
            cnt_s = cnt_r + 7'd1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      S_CRCDEL: begin
        if (!rxbit) begin
          form_s  = 1'b1;
          state_s = S_WAIT_IDLE;
          rec_s   = {RW{1'b0}};
        end else if (!crc_zero) begin
          crcerr_s = 1'b1;
          state_s  = S_WAIT_IDLE;
          rec_s    = {RW{1'b0}};
        end else begin
          state_s = S_ACK;
        end
      end
      S_ACK: begin
        state_s = S_ACKDEL;
      end
      S_ACKDEL: begin
        if (!rxbit) begin
          form_s  = 1'b1;
          state_s = S_WAIT_IDLE;
          rec_s   = {RW{1'b0}};
        end else begin
          cnt_s   = 7'd0;
          state_s = S_EOF;
        end
      end
      S_EOF: begin
        if (!rxbit) begin
          form_s  = 1'b1;
          state_s = S_WAIT_IDLE;
          rec_s   = {RW{1'b0}};
        end else if (cnt_r == 7'(EOF_BITS - 1)) begin
          valid_s = 1'b1;
          state_s = S_IDLE;
        end else begin
          cnt_s = cnt_r + 7'd1;
        end
      end
      default: begin
        state_s = S_WAIT_IDLE;
        rec_s   = {RW{1'b0}};
      end
    endcase
  end

  // Registered outputs; the SOF CRC feed trails crc_clr by one clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_en      <= 1'b0;
      crc_din     <= 1'b0;
      crc_clr     <= 1'b0;
      frame_id    <= 29'd0;
      frame_ide   <= 1'b0;
      frame_rtr   <= 1'b0;
      frame_dlc   <= 4'd0;
      frame_data  <= 64'd0;
      frame_valid <= 1'b0;
      stuff_err   <= 1'b0;
      crc_err     <= 1'b0;
      form_err    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      crc_en      <= sof_pend_r | (sample & en_s);
      crc_din     <= sample & en_s & din_s;
      crc_clr     <= sample & clr_s;
      frame_valid <= sample & valid_s;
      stuff_err   <= sample & stuff_s;
      crc_err     <= sample & crcerr_s;
      form_err    <= sample & form_s;
      if (sample) begin
        busy <= (state_s != S_IDLE);
      end
      if (sample && valid_s) begin
        frame_id   <= id_r;
        frame_rtr  <= rtr_r;
        frame_dlc  <= dlc_r;
        frame_data <= data_r;
`ifdef CAN_EXT_ID_EN
        frame_ide  <= ide_r;
`else
        frame_ide  <= 1'b0;
`endif
      end
    end
  end

endmodule
